// File: rtl/kim_mem_access_stage.sv
// ---------------------------------------------------------------------------
// kim_mem_access_stage
//
// MEM stage of the 5-stage MIPS core, between the EX/MEM and MEM/WB
// pipeline registers. Word loads and stores are run against an external
// data memory over a req/ack handshake of arbitrary latency. While an
// access is outstanding the stage stalls the front of the pipeline. Once
// the access ends, the stage presents the load data and writeback controls
// to MEM/WB for exactly one cycle. Misaligned addresses and bus timeouts
// are reported as one-cycle error pulses.
//
// Ports:
//   clk, rst            pipeline clock; asynchronous active-high reset
//   ex_valid            EX/MEM holds a real instruction (0 = bubble)
//   MemRead, MemWrite   load / store request from EX/MEM
//   MemtoReg, RegWrite  writeback controls from EX/MEM
//   alu_result          effective address, or ALU value for non-memory ops
//   w_data              store data
//   EX_MEM_Rt_or_Rd     destination register index
//   dmem_req/we/addr/wdata  request to the data memory (registered)
//   dmem_ack, dmem_rdata    one-cycle completion pulse and read data
//   mem_stall           hold PC/IF/ID/EX/EX-MEM this cycle
//   MemtoReg_out, RegWrite_out, r_data, alu_result_out, Rt_or_Rd_out
//                       values presented to MEM/WB
//   misalign_err        one-cycle pulse for a misaligned access
//   bus_err             one-cycle pulse for a memory timeout
// ---------------------------------------------------------------------------
module kim_mem_access_stage #(
   parameter int MIPS_REGISTER_DATA_WIDTH = 32,
   parameter int MIPS_REGISTER_ADDR_WIDTH = 5,
   parameter int TIMEOUT_CYCLES           = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                ex_valid,
   input  logic                                MemRead,
   input  logic                                MemWrite,
   input  logic                                MemtoReg,
   input  logic                                RegWrite,
   input  logic [MIPS_REGISTER_DATA_WIDTH-1:0] alu_result,
   input  logic [MIPS_REGISTER_DATA_WIDTH-1:0] w_data,
   input  logic [MIPS_REGISTER_ADDR_WIDTH-1:0] EX_MEM_Rt_or_Rd,
   output logic                                dmem_req,
   output logic                                dmem_we,
   output logic [MIPS_REGISTER_DATA_WIDTH-1:0] dmem_addr,
   output logic [MIPS_REGISTER_DATA_WIDTH-1:0] dmem_wdata,
   input  logic                                dmem_ack,
   input  logic [MIPS_REGISTER_DATA_WIDTH-1:0] dmem_rdata,
   output logic                                mem_stall,
   output logic                                MemtoReg_out,
   output logic                                RegWrite_out,
   output logic [MIPS_REGISTER_DATA_WIDTH-1:0] r_data,
   output logic [MIPS_REGISTER_DATA_WIDTH-1:0] alu_result_out,
   output logic [MIPS_REGISTER_ADDR_WIDTH-1:0] Rt_or_Rd_out,
   output logic                                misalign_err,
   output logic                                bus_err
);

   localparam int DW = MIPS_REGISTER_DATA_WIDTH;

   // Counter only has to reach TIMEOUT_CYCLES-1 before leaving WAIT_ACK.
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [DW-1:0]    ZERO_WORD = {DW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_WAIT_ACK = 2'b01,
      S_DONE     = 2'b10
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic              r_dmem_req;
   logic              r_dmem_we;
   logic [DW-1:0]     r_dmem_addr;
   logic [DW-1:0]     r_dmem_wdata;
   logic [DW-1:0]     r_load_data;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err;
   logic              r_misalign_err;
   logic              r_bus_err;

   logic              w_mem_op;
   logic              w_aligned;
   logic              w_issue;
   logic              w_misalign;
   logic              w_ack_seen;
   logic              w_timeout;
   logic              w_mem_stall;
   logic              w_regwrite_out;
   logic [DW-1:0]     w_r_data;

   assign w_mem_op   = ex_valid & (MemRead | MemWrite);
   assign w_aligned  = (alu_result[1:0] == 2'b00);
   assign w_issue    = (r_state == S_IDLE) & w_mem_op & w_aligned;
   assign w_misalign = (r_state == S_IDLE) & w_mem_op & ~w_aligned;

   // Acks are only honoured while a request is actually outstanding; an ack
   // arriving together with the timeout threshold still completes the access.
   assign w_ack_seen = (r_state == S_WAIT_ACK) & dmem_ack;
   assign w_timeout  = (r_state == S_WAIT_ACK) & ~dmem_ack & (r_cnt == CNT_LAST);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic plus the combinational stall and writeback controls.
   always_comb begin
      w_next_state   = r_state;
      w_mem_stall    = 1'b0;
      w_regwrite_out = 1'b0;
      w_r_data       = ZERO_WORD;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               // Issue cycle: hold the pipeline, bubble MEM/WB.
               w_mem_stall  = 1'b1;
               w_next_state = S_WAIT_ACK;
            end else if (w_mem_op) begin
               // Misaligned access is dropped without a request or stall.
               w_next_state = S_IDLE;
            end else begin
               // Non-memory op: zero-latency pass-through.
               w_regwrite_out = RegWrite & ex_valid;
               w_next_state   = S_IDLE;
            end
         end
         S_WAIT_ACK: begin
            w_mem_stall = 1'b1;
            if (w_ack_seen) begin
               w_next_state = S_DONE;
            end else if (w_timeout) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_WAIT_ACK;
            end
         end
         S_DONE: begin
            // Pipeline advances at the end of this cycle, so MEM/WB sees the
            // result exactly once. Stores never write the register file.
            w_regwrite_out = RegWrite & MemRead & ~r_err;
            if (r_err) begin
               w_r_data = ZERO_WORD;
            end else begin
               w_r_data = r_load_data;
            end
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Memory request registers; held stable from issue until ack or timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= ZERO_WORD;
         r_dmem_wdata <= ZERO_WORD;
      end else begin
         if (w_issue) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= MemWrite;
            r_dmem_addr  <= alu_result;
            r_dmem_wdata <= w_data;
         end else if (w_ack_seen | w_timeout) begin
            r_dmem_req <= 1'b0;
         end
      end
   end

   // WAIT_ACK cycle counter, restarted on every issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= CNT_ZERO;
      end else begin
         if (w_issue) begin
            r_cnt <= CNT_ZERO;
         end else if (r_state == S_WAIT_ACK) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   // Load data capture; store acks leave the previous value untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_data <= ZERO_WORD;
      end else begin
         if (w_ack_seen & ~r_dmem_we) begin
            r_load_data <= dmem_rdata;
         end
      end
   end

   // Error flag marks a timed-out access until DONE has been presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         if (w_timeout) begin
            r_err <= 1'b1;
         end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
         end
      end
   end

   // One-cycle registered error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign_err <= 1'b0;
         r_bus_err      <= 1'b0;
      end else begin
         r_misalign_err <= w_misalign;
         r_bus_err      <= w_timeout;
      end
   end

   assign dmem_req       = r_dmem_req;
   assign dmem_we        = r_dmem_we;
   assign dmem_addr      = r_dmem_addr;
   assign dmem_wdata     = r_dmem_wdata;
   assign mem_stall      = w_mem_stall;
   assign RegWrite_out   = w_regwrite_out;
   assign r_data         = w_r_data;
   assign misalign_err   = r_misalign_err;
   assign bus_err        = r_bus_err;

   // EX/MEM is held during a stall, so these can pass straight through.
   assign MemtoReg_out   = MemtoReg;
   assign alu_result_out = alu_result;
   assign Rt_or_Rd_out   = EX_MEM_Rt_or_Rd;

endmodule

// File: tb/tb_kim_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_kim_mem_access_stage
//
// Directed testbench for kim_mem_access_stage. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later, well away from the
// rising (active) edge. Each scenario task does its own comparisons.
// ---------------------------------------------------------------------------
module tb_kim_mem_access_stage;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic [31:0] alu_result;
   logic [31:0] w_data;
   logic [4:0]  dest;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic [31:0] r_data;
   logic [31:0] alu_result_out;
   logic [4:0]  rt_or_rd_out;
   logic        misalign_err;
   logic        bus_err;

   int n_pass;
   int n_total;

   kim_mem_access_stage #(
      .MIPS_REGISTER_DATA_WIDTH(32),
      .MIPS_REGISTER_ADDR_WIDTH(5),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid       (ex_valid),
      .MemRead        (mem_read),
      .MemWrite       (mem_write),
      .MemtoReg       (mem_to_reg),
      .RegWrite       (reg_write),
      .alu_result     (alu_result),
      .w_data         (w_data),
      .EX_MEM_Rt_or_Rd(dest),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_ack       (dmem_ack),
      .dmem_rdata     (dmem_rdata),
      .mem_stall      (mem_stall),
      .MemtoReg_out   (mem_to_reg_out),
      .RegWrite_out   (reg_write_out),
      .r_data         (r_data),
      .alu_result_out (alu_result_out),
      .Rt_or_Rd_out   (rt_or_rd_out),
      .misalign_err   (misalign_err),
      .bus_err        (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_bubble;
      ex_valid   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_result = 32'h0;
      w_data     = 32'h0;
      dest       = 5'd0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive_bubble();
      @(negedge clk);
      @(negedge clk);
      #1;
      n_total++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem_req); else n_pass++;
      n_total++; if (dmem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", dmem_we); else n_pass++;
      n_total++; if (dmem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", dmem_addr); else n_pass++;
      n_total++; if (dmem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", dmem_wdata); else n_pass++;
      n_total++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else n_pass++;
      n_total++; if (misalign_err !== 1'b0 || bus_err !== 1'b0)
         $display("FAIL reset_errs: got %b%b want 00", misalign_err, bus_err); else n_pass++;
      n_total++; if (reg_write_out !== 1'b0 || r_data !== 32'h0)
         $display("FAIL reset_wb: got rw=%b rd=%h want 0/0", reg_write_out, r_data); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Load at 0x10, ack on the third WAIT_ACK cycle: 4 stall cycles, then DONE.
   task automatic test_load;
      int stalls;
      int wr_hi;
      bit fin;
      stalls = 0; wr_hi = 0; fin = 1'b0;
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      reg_write = 1'b1; alu_result = 32'h0000_0010; dest = 5'd9;
      for (int c = 0; c < 12 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ack   = (c == 3);
         dmem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
         #1;
         if (reg_write_out === 1'b1) wr_hi++;
         if (c == 1) begin
            n_total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h10)
               $display("FAIL load_req: got req=%b we=%b addr=%h want 1/0/00000010", dmem_req, dmem_we, dmem_addr);
            else n_pass++;
         end
         if (mem_stall === 1'b1) begin
            stalls++;
         end else begin
            fin = 1'b1;
            n_total++; if (r_data !== 32'hDEAD_BEEF) $display("FAIL load_rdata: got %h want deadbeef", r_data); else n_pass++;
            n_total++; if (reg_write_out !== 1'b1) $display("FAIL load_regwrite: got %b want 1", reg_write_out); else n_pass++;
            n_total++; if (rt_or_rd_out !== 5'd9 || mem_to_reg_out !== 1'b1)
               $display("FAIL load_dest: got rd=%0d m2r=%b want 9/1", rt_or_rd_out, mem_to_reg_out); else n_pass++;
            n_total++; if (dmem_req !== 1'b0) $display("FAIL load_req_drop: got %b want 0", dmem_req); else n_pass++;
         end
      end
      dmem_ack = 1'b0;
      n_total++; if (!fin) $display("FAIL load_done_timeout: got no DONE want DONE within 12 cycles"); else n_pass++;
      n_total++; if (stalls != 4) $display("FAIL load_stall_cycles: got %0d want 4", stalls); else n_pass++;
      @(negedge clk);
      drive_bubble();
      #1;
      if (reg_write_out === 1'b1) wr_hi++;
      n_total++; if (mem_stall !== 1'b0) $display("FAIL load_after_stall: got %b want 0", mem_stall); else n_pass++;
      n_total++; if (wr_hi != 1) $display("FAIL load_regwrite_count: got %0d want 1", wr_hi); else n_pass++;
   endtask

   // Store at 0x20 with RegWrite deliberately set; ack on second WAIT_ACK cycle.
   task automatic test_store;
      int stalls;
      int wr_hi;
      bit fin;
      stalls = 0; wr_hi = 0; fin = 1'b0;
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_to_reg = 1'b0;
      reg_write = 1'b1; alu_result = 32'h0000_0020; w_data = 32'h1234_5678; dest = 5'd4;
      for (int c = 0; c < 12 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ack   = (c == 2);
         dmem_rdata = 32'hFFFF_0000;
         #1;
         if (reg_write_out === 1'b1) wr_hi++;
         if (c == 1 || c == 2) begin
            n_total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h20 || dmem_wdata !== 32'h1234_5678)
               $display("FAIL store_req_c%0d: got req=%b we=%b addr=%h wd=%h want 1/1/00000020/12345678",
                        c, dmem_req, dmem_we, dmem_addr, dmem_wdata);
            else n_pass++;
         end
         if (mem_stall === 1'b1) stalls++;
         else fin = 1'b1;
      end
      dmem_ack = 1'b0;
      n_total++; if (!fin) $display("FAIL store_done_timeout: got no DONE want DONE within 12 cycles"); else n_pass++;
      n_total++; if (stalls != 3) $display("FAIL store_stall_cycles: got %0d want 3", stalls); else n_pass++;
      n_total++; if (dmem_req !== 1'b0) $display("FAIL store_req_drop: got %b want 0", dmem_req); else n_pass++;
      @(negedge clk);
      drive_bubble();
      #1;
      n_total++; if (wr_hi != 0) $display("FAIL store_regwrite: got %0d cycles want 0", wr_hi); else n_pass++;
   endtask

   // Misaligned load at 0x13: no request, no stall, one-cycle error pulse.
   task automatic test_misalign;
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      reg_write = 1'b1; alu_result = 32'h0000_0013; dest = 5'd7;
      #1;
      n_total++; if (mem_stall !== 1'b0 || reg_write_out !== 1'b0)
         $display("FAIL misalign_issue: got stall=%b rw=%b want 0/0", mem_stall, reg_write_out); else n_pass++;
      @(negedge clk);
      drive_bubble();
      #1;
      n_total++; if (misalign_err !== 1'b1) $display("FAIL misalign_pulse: got %b want 1", misalign_err); else n_pass++;
      n_total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0)
         $display("FAIL misalign_noreq: got req=%b stall=%b want 0/0", dmem_req, mem_stall); else n_pass++;
      @(negedge clk);
      #1;
      n_total++; if (misalign_err !== 1'b0) $display("FAIL misalign_width: got %b want 0", misalign_err); else n_pass++;
   endtask

   // Load with no ack (timeout) or ack on the 16th WAIT_ACK cycle (ack wins).
   task automatic test_timeout(input bit ack_last);
      int stalls;
      int req_hi;
      bit fin;
      stalls = 0; req_hi = 0; fin = 1'b0;
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      reg_write = 1'b1; alu_result = 32'h0000_0040; dest = 5'd12;
      for (int c = 0; c < 30 && !fin; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ack   = ack_last && (c == 16);
         dmem_rdata = (ack_last && c == 16) ? 32'hCAFE_F00D : 32'h5555_AAAA;
         #1;
         if (dmem_req === 1'b1) req_hi++;
         if (mem_stall === 1'b1) begin
            stalls++;
         end else begin
            fin = 1'b1;
            n_total++; if (bus_err !== !ack_last) $display("FAIL tmo%0d_bus_err: got %b want %b", ack_last, bus_err, !ack_last); else n_pass++;
            n_total++; if (reg_write_out !== ack_last) $display("FAIL tmo%0d_regwrite: got %b want %b", ack_last, reg_write_out, ack_last); else n_pass++;
            n_total++; if (r_data !== (ack_last ? 32'hCAFE_F00D : 32'h0))
               $display("FAIL tmo%0d_rdata: got %h want %h", ack_last, r_data, ack_last ? 32'hCAFE_F00D : 32'h0); else n_pass++;
            n_total++; if (dmem_req !== 1'b0) $display("FAIL tmo%0d_req_drop: got %b want 0", ack_last, dmem_req); else n_pass++;
         end
      end
      dmem_ack = 1'b0;
      n_total++; if (!fin) $display("FAIL tmo%0d_done_timeout: got no DONE want DONE within 30 cycles", ack_last); else n_pass++;
      n_total++; if (stalls != 17) $display("FAIL tmo%0d_stall_cycles: got %0d want 17", ack_last, stalls); else n_pass++;
      n_total++; if (req_hi != 16) $display("FAIL tmo%0d_req_cycles: got %0d want 16", ack_last, req_hi); else n_pass++;
      @(negedge clk);
      drive_bubble();
      #1;
      n_total++; if (bus_err !== 1'b0 || mem_stall !== 1'b0)
         $display("FAIL tmo%0d_after: got berr=%b stall=%b want 0/0", ack_last, bus_err, mem_stall); else n_pass++;
   endtask

   // Back-to-back ALU ops with stray acks: zero stall, RegWrite_out each cycle.
   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
         reg_write = 1'b1; alu_result = 32'h0000_0042; dest = 5'(i + 1);
         dmem_ack = (i % 2 == 0); dmem_rdata = 32'hBAD0_BAD0;
         #1;
         n_total++; if (mem_stall !== 1'b0 || reg_write_out !== 1'b1 || alu_result_out !== 32'h42 || rt_or_rd_out !== 5'(i + 1))
            $display("FAIL b2b_%0d: got stall=%b rw=%b alu=%h rd=%0d want 0/1/00000042/%0d",
                     i, mem_stall, reg_write_out, alu_result_out, rt_or_rd_out, i + 1);
         else n_pass++;
         n_total++; if (dmem_req !== 1'b0 || r_data !== 32'h0)
            $display("FAIL b2b_stray_ack_%0d: got req=%b rd=%h want 0/0", i, dmem_req, r_data); else n_pass++;
      end
      @(negedge clk);
      drive_bubble();
      reg_write = 1'b1;
      #1;
      n_total++; if (reg_write_out !== 1'b0 || mem_stall !== 1'b0)
         $display("FAIL bubble_idle: got rw=%b stall=%b want 0/0", reg_write_out, mem_stall); else n_pass++;
   endtask

   // Reset while in WAIT_ACK, then a late ack that must be ignored.
   task automatic test_reset_mid_access;
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
      reg_write = 1'b1; alu_result = 32'h0000_0080; dest = 5'd2;
      repeat (3) @(negedge clk);
      #1;
      n_total++; if (dmem_req !== 1'b1) $display("FAIL rstmid_pre_req: got %b want 1", dmem_req); else n_pass++;
      rst = 1'b1;
      drive_bubble();
      #1;
      n_total++; if (dmem_req !== 1'b0 || dmem_addr !== 32'h0 || mem_stall !== 1'b0)
         $display("FAIL rstmid_async: got req=%b addr=%h stall=%b want 0/0/0", dmem_req, dmem_addr, mem_stall); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
      #1;
      n_total++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || reg_write_out !== 1'b0)
         $display("FAIL rstmid_late_ack: got req=%b stall=%b rw=%b want 0/0/0", dmem_req, mem_stall, reg_write_out); else n_pass++;
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      n_total++; if (mem_stall !== 1'b0 || reg_write_out !== 1'b0 || r_data !== 32'h0 || bus_err !== 1'b0)
         $display("FAIL rstmid_after: got stall=%b rw=%b rd=%h berr=%b want 0/0/0/0",
                  mem_stall, reg_write_out, r_data, bus_err); else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_load();
      test_store();
      test_misalign();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_back_to_back();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/kim_mem_access_stage.md
Name: kim_mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage MIPS core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Runs word loads and stores against an external data memory over a req/ack handshake. The memory may take many cycles.
- Stalls the pipeline while an access is outstanding and produces the load data, ALU result, destination register and writeback controls for MEM/WB.
- Detects misaligned addresses and bus timeouts, and flags them.

Parameters:
- MIPS_REGISTER_DATA_WIDTH, 32, datapath and memory word width.
- MIPS_REGISTER_ADDR_WIDTH, 5, register-file index width.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT_ACK before a bus error is declared (minimum 2).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- ex_valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- MemRead  in  1  load.
- MemWrite  in  1  store.
- MemtoReg  in  1  writeback selects memory data.
- RegWrite  in  1  instruction writes the register file.
- alu_result  in  DATA_W  effective address, or ALU value for non-memory ops.
- w_data  in  DATA_W  store data.
- EX_MEM_Rt_or_Rd  in  ADDR_W  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  byte address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack.
- mem_stall  out  1  hold PC/IF/ID/EX/EX-MEM this cycle.
- MemtoReg_out  out  1  to MEM/WB.
- RegWrite_out  out  1  to MEM/WB; 0 inserts a bubble.
- r_data  out  DATA_W  load data to MEM/WB.
- alu_result_out  out  DATA_W  to MEM/WB.
- Rt_or_Rd_out  out  ADDR_W  to MEM/WB.
- misalign_err  out  1  one-cycle error pulse.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Interface decided: one clock (clk); reset rst is asynchronous and active-high.
- Reset state: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, load register=0, timeout counter=0, misalign_err=0, bus_err=0.
- Definitions:
  - mem_op = ex_valid & (MemRead | MemWrite).
  - aligned = (alu_result[1:0] == 0).
- FSM states: IDLE, WAIT_ACK, DONE.
- IDLE:
  - If mem_op & aligned: mem_stall=1 combinationally and RegWrite_out=0. Next edge: WAIT_ACK, dmem_req<=1, dmem_we<=MemWrite, dmem_addr<=alu_result, dmem_wdata<=w_data, counter<=0.
  - If mem_op & !aligned: no request and no stall. RegWrite_out=0. misalign_err registered high for exactly one cycle. Stay IDLE.
  - Otherwise, pass-through with zero latency: RegWrite_out = RegWrite & ex_valid, r_data=0, mem_stall=0.
- WAIT_ACK:
  - mem_stall=1, RegWrite_out=0.
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack or timeout.
  - counter increments every cycle.
  - On dmem_ack: load register<=dmem_rdata (loads only), dmem_req<=0, go DONE.
  - Else if counter==TIMEOUT_CYCLES-1: dmem_req<=0, bus_err<=1 (one cycle), error flag set, go DONE.
- DONE:
  - mem_stall=0.
  - RegWrite_out = RegWrite & MemRead & !error flag.
  - r_data = load register, or 0 on error.
  - Go IDLE next edge; clear the error flag.
  - The pipeline advances at the end of DONE, so MEM/WB captures the result exactly once.
- Access latency: a load with ack on cycle N after request assertion leaves DONE at cycle N+1. Minimum total stall is 2 cycles (issue cycle plus WAIT_ACK), plus DONE.
- Pass-through signals: MemtoReg_out, alu_result_out and Rt_or_Rd_out always reflect the EX/MEM inputs, which are held during stall.
- Stores never assert RegWrite_out.
- dmem_ack while dmem_req=0 (IDLE or DONE) is ignored; no state change.
- dmem_ack on the same cycle as the timeout threshold: ack wins, no bus_err.
- rst asserted mid-access: immediate return to IDLE with dmem_req=0. A late ack after reset is ignored.
- ex_valid=0 in IDLE: everything idle, RegWrite_out=0.

Test Plan:
- Reset while in WAIT_ACK → dmem_req=0, state IDLE, mem_stall=0 next cycle, all outputs at reset values.
- Load at 0x0000_0010, ack 3 cycles after req, rdata=0xDEAD_BEEF → mem_stall high 4 cycles, DONE r_data=0xDEAD_BEEF, RegWrite_out=1 for one cycle, Rt_or_Rd_out=dest.
- Store addr 0x20, w_data 0x1234_5678, ack after 1 cycle → dmem_we=1, addr/wdata stable until ack, RegWrite_out never 1.
- Load at 0x0000_0013 → no dmem_req, misalign_err single-cycle pulse, mem_stall=0, RegWrite_out=0.
- Load with no ack, TIMEOUT_CYCLES=16 → dmem_req drops after 16 WAIT_ACK cycles, bus_err pulse, DONE with RegWrite_out=0, r_data=0. Repeat with ack on cycle 16 → ack wins, no bus_err.
- ALU op (RegWrite=1, alu_result=0x42) back-to-back with stray dmem_ack pulses → zero stall, RegWrite_out=1 each cycle, alu_result_out=0x42, stray acks ignored.
